// File: rtl/pad_event_encoder.sv
// pad_event_encoder: synchronizes N_PADS raw pad levels, filters them, turns
// rising edges of the filtered level into press events and queues the pad
// indices in a small FIFO for a valid/ready consumer.
//
// Build option: define PAD_DEBOUNCE_EN to give every pad a DB_CYCLES-long
// debounce counter. Without it the filtered state is sync2 delayed by one clock,
// and DB_CYCLES has no effect.
//
// Handshake: ev_valid/ev_idx come from registered FIFO state only. An event is
// consumed on the rising edge where ev_valid && ev_ready. ev_idx is held stable
// while ev_valid is high and ev_ready is low.
module pad_event_encoder #(
   parameter int N_PADS     = 12,
   parameter int IDX_W      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int DB_CYCLES  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_PADS-1:0] pad_in,
   input  logic              ev_ready,
   input  logic              ovf_clr,
   output logic              ev_valid,
   output logic [IDX_W-1:0]  ev_idx,
   output logic              any_held,
   output logic              overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [N_PADS-1:0] sync1;
   logic [N_PADS-1:0] sync2;
   logic [N_PADS-1:0] st;
   logic [N_PADS-1:0] st_next;
   logic [N_PADS-1:0] press;
   logic [N_PADS-1:0] pending;
   logic [N_PADS-1:0] low_mask;
   logic [N_PADS-1:0] clr_mask;
   logic [IDX_W-1:0]  push_idx;
   logic              push;
   logic              pop;
   logic              empty;
   logic              full;
   logic              ovf_set;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [IDX_W-1:0]  mem [FIFO_DEPTH];

   // Two-flop synchronizer; nothing downstream sees pad_in directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pad_in;
         sync2 <= sync1;
      end
   end

`ifdef PAD_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic [CW-1:0] db_cnt [N_PADS];

   // A pad flips once its synchronized level has disagreed for DB_CYCLES clocks.
   always_comb begin
      st_next = st;
      for (int i = 0; i < N_PADS; i++) begin
         if ((sync2[i] != st[i]) && (db_cnt[i] == DB_LAST)) begin
            st_next[i] = ~st[i];
         end
      end
   end

   // Per-pad mismatch counters: count while disagreeing, restart on agreement or flip.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_PADS; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_PADS; i++) begin
            if ((sync2[i] == st[i]) || (db_cnt[i] == DB_LAST)) begin
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CW'(1);
            end
         end
      end
   end
`else
   // Filtered state is simply sync2 one clock later.
   assign st_next = sync2;
`endif

   // Filtered pad state and the registered any-held summary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= '0;
         any_held <= 1'b0;
      end else begin
         st       <= st_next;
         any_held <= |st;
      end
   end

   assign press = st_next & ~st;

   // Lowest-index pending pad: scan downward so the lowest set bit wins.
   always_comb begin
      push_idx = '0;
      low_mask = '0;
      for (int i = N_PADS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            push_idx    = IDX_W'(i);
            low_mask    = '0;
            low_mask[i] = 1'b1;
         end
      end
   end

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop      = ~empty & ev_ready;
   assign push     = (|pending) & (~full | pop);
   assign clr_mask = push ? low_mask : '0;
   // A new press on a pad whose earlier press is still waiting gets merged.
   assign ovf_set  = |(press & pending & ~clr_mask);

   // Pending mask: collect new presses, retire the bit moved into the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr_mask) | press;
      end
   end

   // Sticky overflow; a new merge wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_idx;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   assign ev_valid = ~empty;
   assign ev_idx   = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_pad_event_encoder.sv
// Bench for pad_event_encoder: directed scenarios plus randomized pad traffic
// compared against a reference model in which the filtered level of a pad is
// its input level two clocks earlier, pending presses form a set and delivered
// events form a queue.
module tb_pad_event_encoder;

   localparam int N  = 12;
   localparam int IW = 4;
   localparam int D  = 4;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  pad_in;
   logic          ev_ready;
   logic          ovf_clr;
   logic          ev_valid;
   logic [IW-1:0] ev_idx;
   logic          any_held;
   logic          overflow;

   int total;
   int bad;

   // reference model state
   logic [N-1:0]  hist [4];
   logic [N-1:0]  m_pend;
   logic          m_ovf;
   logic [IW-1:0] exp_q [$];

   pad_event_encoder #(.N_PADS(N), .IDX_W(IW), .FIFO_DEPTH(D), .DB_CYCLES(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pad_in   (pad_in),
      .ev_ready (ev_ready),
      .ovf_clr  (ovf_clr),
      .ev_valid (ev_valid),
      .ev_idx   (ev_idx),
      .any_held (any_held),
      .overflow (overflow)
   );

   // clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) hist[i] = '0;
      m_pend = '0;
      m_ovf  = 1'b0;
      exp_q.delete();
   endtask

   // One rising edge of the abstract model, using the inputs now applied.
   task automatic model_edge();
      logic [N-1:0] press;
      logic [N-1:0] taken;
      taken = '0;
      if (exp_q.size() > 0 && ev_ready) void'(exp_q.pop_front());
      if (m_pend != '0 && exp_q.size() < D) begin
         for (int i = 0; i < N; i++) begin
            if (m_pend[i]) begin
               exp_q.push_back(IW'(i));
               taken[i] = 1'b1;
               break;
            end
         end
      end
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = pad_in;
      press = hist[2] & ~hist[3];
      if ((press & m_pend & ~taken) != '0) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_pend = (m_pend & ~taken) | press;
   endtask

   // driver: advance one clock, inputs change and outputs are sampled at negedge
   task automatic tick();
      if (rst_n) model_edge();
      else model_reset();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pad_in = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
      model_reset();
      idle(3);
      total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", ev_valid); end
      total++; if (ev_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d want=0", ev_idx); end
      total++; if (any_held !== 1'b0) begin bad++; $display("FAIL reset_any got=%0b want=0", any_held); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", overflow); end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_single_press();
      pad_in = N'(1) << 5; ev_ready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tick();
         total++; if (ev_valid !== (j == 3)) begin bad++; $display("FAIL single_valid edge+%0d got=%0b want=%0b", j, ev_valid, (j == 3)); end
         total++; if (any_held !== (j >= 3)) begin bad++; $display("FAIL single_any edge+%0d got=%0b want=%0b", j, any_held, (j >= 3)); end
         if (j == 3) begin
            total++; if (ev_idx !== 4'd5) begin bad++; $display("FAIL single_idx got=%0d want=5", ev_idx); end
         end
      end
      pad_in = '0;
      idle(5);
      total++; if (any_held !== 1'b0) begin bad++; $display("FAIL single_release_any got=%0b want=0", any_held); end
   endtask

   task automatic test_simultaneous();
      logic [IW-1:0] want;
      pad_in = '0; pad_in[2] = 1'b1; pad_in[7] = 1'b1; pad_in[11] = 1'b1; ev_ready = 1'b1;
      for (int j = 0; j < 7; j++) begin
         tick();
         want = (j == 3) ? 4'd2 : (j == 4) ? 4'd7 : 4'd11;
         total++; if (ev_valid !== (j >= 3 && j <= 5)) begin bad++; $display("FAIL simul_valid edge+%0d got=%0b", j, ev_valid); end
         if (j >= 3 && j <= 5) begin
            total++; if (ev_idx !== want) begin bad++; $display("FAIL simul_idx edge+%0d got=%0d want=%0d", j, ev_idx, want); end
         end
      end
      pad_in = '0;
      idle(5);
   endtask

   task automatic test_backpressure();
      logic [IW-1:0] got [$];
      ev_ready = 1'b0; pad_in = 12'h03F;
      tick();
      pad_in = '0;
      idle(9);
      total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL bp_full_valid got=%0b want=1", ev_valid); end
      total++; if (ev_idx !== 4'd0) begin bad++; $display("FAIL bp_head got=%0d want=0", ev_idx); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf got=%0b want=0", overflow); end
      ev_ready = 1'b1;
      for (int c = 0; c < 20 && got.size() < 6; c++) begin
         if (ev_valid) got.push_back(ev_idx);
         tick();
      end
      total++; if (got.size() != 6) begin bad++; $display("FAIL bp_count got=%0d want=6", got.size()); end
      for (int i = 0; i < got.size() && i < 6; i++) begin
         total++; if (got[i] !== IW'(i)) begin bad++; $display("FAIL bp_order pos=%0d got=%0d want=%0d", i, got[i], i); end
      end
      idle(2);
      total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0b want=0", ev_valid); end
   endtask

   task automatic test_overflow();
      logic [IW-1:0] got [$];
      ev_ready = 1'b0; pad_in = 12'h01F;
      tick();
      pad_in = '0;
      idle(3);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b want=0", overflow); end
      pad_in = N'(1) << 4;
      tick();
      pad_in = '0;
      idle(4);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", overflow); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0b want=0", overflow); end
      tick();
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_stay got=%0b want=0", overflow); end
      ev_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (ev_valid) got.push_back(ev_idx);
         tick();
      end
      total++; if (got.size() != 5) begin bad++; $display("FAIL ovf_merged_count got=%0d want=5", got.size()); end
      for (int i = 0; i < got.size() && i < 5; i++) begin
         total++; if (got[i] !== IW'(i)) begin bad++; $display("FAIL ovf_order pos=%0d got=%0d want=%0d", i, got[i], i); end
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      ev_ready = 1'b0; pad_in = 12'h00E;
      idle(7);
      total++; if (ev_valid !== 1'b1 || any_held !== 1'b1) begin bad++; $display("FAIL mid_prep valid=%0b any=%0b want=1,1", ev_valid, any_held); end
      #2;
      rst_n = 1'b0; pad_in = '0;
      model_reset();
      #1;
      total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b want=0", ev_valid); end
      total++; if (any_held !== 1'b0) begin bad++; $display("FAIL mid_any got=%0b want=0", any_held); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%0b want=0", overflow); end
      total++; if (ev_idx !== '0) begin bad++; $display("FAIL mid_idx got=%0d want=0", ev_idx); end
      @(negedge clk);
      idle(2);
      rst_n = 1'b1; ev_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (ev_valid) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL mid_stale got=%0d want=0", seen); end
   endtask

   task automatic test_hold_across_reset();
      ev_ready = 1'b0; pad_in = N'(1) << 6;
      idle(6);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1; ev_ready = 1'b1;
      for (int j = 0; j < 7; j++) begin
         tick();
         total++; if (ev_valid !== (j == 3)) begin bad++; $display("FAIL hold_valid edge+%0d got=%0b want=%0b", j, ev_valid, (j == 3)); end
         if (j == 3) begin
            total++; if (ev_idx !== 4'd6) begin bad++; $display("FAIL hold_idx got=%0d want=6", ev_idx); end
         end
      end
      pad_in = '0;
      idle(5);
   endtask

   task automatic test_random();
      int bit_sel;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(3) == 0) begin
            bit_sel = $urandom_range(N - 1);
            pad_in[bit_sel] = ~pad_in[bit_sel];
         end
         if ((c % 100) < 50) ev_ready = ($urandom_range(3) == 0);
         else ev_ready = ($urandom_range(3) != 0);
         ovf_clr = ($urandom_range(15) == 0);
         tick();
         total++; if (ev_valid !== (exp_q.size() > 0)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", c, ev_valid, (exp_q.size() > 0)); end
         if (exp_q.size() > 0) begin
            total++; if (ev_idx !== exp_q[0]) begin bad++; $display("FAIL rand_idx cyc=%0d got=%0d want=%0d", c, ev_idx, exp_q[0]); end
         end
         total++; if (any_held !== (|hist[3])) begin bad++; $display("FAIL rand_any cyc=%0d got=%0b want=%0b", c, any_held, (|hist[3])); end
         total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rand_ovf cyc=%0d got=%0b want=%0b", c, overflow, m_ovf); end
      end
      pad_in = '0; ovf_clr = 1'b0;
   endtask

   task automatic test_debounce();
      int seen;
      logic [IW-1:0] idx_seen;
      ev_ready = 1'b1;
      pad_in = N'(1) << 3;
      idle(3);
      pad_in = '0;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (ev_valid) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL db_glitch got=%0d want=0", seen); end
      pad_in = N'(1) << 3;
      idle(4);
      pad_in = '0;
      seen = 0; idx_seen = '0;
      for (int c = 0; c < 20; c++) begin
         if (ev_valid) begin seen++; idx_seen = ev_idx; end
         tick();
      end
      total++; if (seen != 1) begin bad++; $display("FAIL db_count got=%0d want=1", seen); end
      total++; if (idx_seen !== 4'd3) begin bad++; $display("FAIL db_idx got=%0d want=3", idx_seen); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0; pad_in = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
      @(negedge clk);
      test_reset();
`ifdef PAD_DEBOUNCE_EN
      test_debounce();
`else
      test_single_press();
      test_simultaneous();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_hold_across_reset();
      test_random();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
